// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment readback path.
// Segments are active-low, listed g..a (bit 0 = a); digit enables are active-low.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] EN_D0   = 4'b1110;
  localparam logic [3:0] EN_D1   = 4'b1101;
  localparam logic [3:0] EN_D2   = 4'b1011;
  localparam logic [3:0] EN_D3   = 4'b0111;
  localparam logic [3:0] EN_NONE = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } cap_state_t;

  // A scan pattern is usable only when exactly one digit is selected.
  function automatic logic en_one_low(input logic [3:0] en);
    return ($countones(~en) == 1);
  endfunction

  function automatic logic [1:0] en_index(input logic [3:0] en);
    logic [1:0] idx;
    case (en)
      EN_D1:   idx = 2'd1;
      EN_D2:   idx = 2'd2;
      EN_D3:   idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational active-low segment pattern to nibble decoder.
// Blank decodes to 4'hF; anything outside the table also yields 4'hF with o_unknown set.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_val,
  output logic       o_unknown
);

  always_comb begin
    o_val     = 4'hF;
    o_unknown = 1'b0;
    case (i_seg)
      SEG_0:     o_val = 4'h0;
      SEG_1:     o_val = 4'h1;
      SEG_2:     o_val = 4'h2;
      SEG_3:     o_val = 4'h3;
      SEG_4:     o_val = 4'h4;
      SEG_5:     o_val = 4'h5;
      SEG_6:     o_val = 4'h6;
      SEG_7:     o_val = 4'h7;
      SEG_8:     o_val = 4'h8;
      SEG_9:     o_val = 4'h9;
      SEG_BLANK: o_val = 4'hF;
      default:   o_unknown = 1'b1;
    endcase
  end

endmodule

// File: rtl/display_capture.sv
// Recovers the four displayed nibbles from a multiplexed 7-segment bus.
// Optional feature macro DISPLAY_CAPTURE_SEG_ERR_EN: flag undecodable patterns (value 4'hE, seg_err pulse).
module display_capture
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] enabled,
  input  logic [6:0] ag,
  output logic [3:0] d3,
  output logic [3:0] d2,
  output logic [3:0] d1,
  output logic [3:0] d0,
  output logic [3:0] digit_valid,
  output logic       frame_done,
  output logic       stale,
  output logic       seg_err,
  output cap_state_t dbg_state
);

  localparam int CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  // Sample register and stability tracking
  logic [3:0]       r_en;
  logic [6:0]       r_ag;
  logic             r_chg;
  logic [CNT_W-1:0] r_cnt;
  logic             w_diff;

  assign w_diff = ({enabled, ag} != {r_en, r_ag});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en  <= EN_NONE;
      r_ag  <= SEG_BLANK;
      r_chg <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_en  <= enabled;
      r_ag  <= ag;
      r_chg <= w_diff;
      if (w_diff)
        r_cnt <= '0;
      else if (r_cnt != CNT_MAX)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Decode of the held sample
  logic [3:0] w_dec;
  logic       w_unknown;
  logic [3:0] w_val;
  logic       w_err;

  seg7_decode u_decode (
    .i_seg     (r_ag),
    .o_val     (w_dec),
    .o_unknown (w_unknown)
  );

`ifdef DISPLAY_CAPTURE_SEG_ERR_EN
  assign w_val = w_unknown ? 4'hE : w_dec;
  assign w_err = w_unknown;
`else
  assign w_val = w_unknown ? 4'hF : w_dec;
  assign w_err = 1'b0;
`endif

  // FSM, capture, frame and timeout state
  cap_state_t      r_state;
  logic [3:0]      r_d [4];
  logic [3:0]      r_valid;
  logic [3:0]      r_mask;
  logic            r_frame;
  logic            r_stale;
  logic            r_err;
  logic [TO_W-1:0] r_to;

  logic       w_capture;
  logic [3:0] w_sel;
  logic [1:0] w_idx;
  logic [3:0] w_mask_nx;

  // r_chg reflects a change seen on the previous edge, so the counter value
  // read here belongs to the same held sample that r_ag/r_en carry.
  assign w_capture = (r_state == ST_SETTLE) && !r_chg && (r_cnt == CNT_MAX);
  assign w_sel     = ~r_en;
  assign w_idx     = en_index(r_en);
  assign w_mask_nx = r_mask | w_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_d[0]  <= 4'hF;
      r_d[1]  <= 4'hF;
      r_d[2]  <= 4'hF;
      r_d[3]  <= 4'hF;
      r_valid <= 4'b0000;
      r_mask  <= 4'b0000;
      r_frame <= 1'b0;
      r_stale <= 1'b0;
      r_err   <= 1'b0;
      r_to    <= '0;
    end else begin
      r_frame <= 1'b0;
      r_err   <= 1'b0;

      if (r_chg)
        r_state <= en_one_low(r_en) ? ST_SETTLE : ST_IDLE;
      else if (w_capture)
        r_state <= ST_HELD;

      // A capture on the expiry cycle takes priority, so stale never rises then.
      if (w_capture) begin
        r_d[w_idx] <= w_val;
        r_valid    <= r_valid | w_sel;
        r_to       <= '0;
        r_stale    <= 1'b0;
        r_err      <= w_err;
        if (w_mask_nx == 4'b1111) begin
          r_frame <= 1'b1;
          r_mask  <= 4'b0000;
        end else begin
          r_mask  <= w_mask_nx;
        end
      end else if (r_to != TO_MAX) begin
        r_to <= r_to + TO_W'(1);
        if (r_to == TO_LAST) begin
          r_stale <= 1'b1;
          r_valid <= 4'b0000;
          r_mask  <= 4'b0000;
        end
      end
    end
  end

  assign d0          = r_d[0];
  assign d1          = r_d[1];
  assign d2          = r_d[2];
  assign d3          = r_d[3];
  assign digit_valid = r_valid;
  assign frame_done  = r_frame;
  assign stale       = r_stale;
  assign seg_err     = r_err;
  assign dbg_state   = r_state;

endmodule
